vga_obj_engine: RTL
===================

# vga_obj_engine

Parametrised VGA timing generator and multi-object renderer. It draws up to N_OBJ independently positioned, sized and coloured shapes (square, circle, triangle) over a background colour. Object attributes arrive through a valid/ready command port, normally driven by the IR-remote decoder glue, and are double-buffered so each change takes effect at a frame boundary. It sits between the IR command logic and the VGA DAC pins; `clk` is the pixel clock.

## Interface
- H_ACT, 640, active pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACT, 480, active lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- N_OBJ, 4, number of objects (power of two, 2..8)
- BG, 24'h000000, background colour {R,G,B}
- clk  in  1  pixel clock (25 MHz nominal)
- rst  in  1  reset: asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_obj  in  log2(N_OBJ)  target object index
- cmd_field  in  3  0=X, 1=Y, 2=R (half-size/radius), 3=shape, 4=colour; 5..7 are ignored but still accepted
- cmd_data  in  24  field value; X,Y,R use [10:0], shape uses [1:0] (0 none, 1 square, 2 circle, 3 triangle)
- vga_hs, vga_vs  out  1  syncs, active-low
- vga_blank_n  out  1  high during active video
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse on the commit cycle

## Operation
- Counters: h runs 0..H_TOTAL-1, then wraps and increments v; v runs 0..V_TOTAL-1, then wraps. H_TOTAL is the sum of the H parameters; V_TOTAL likewise.
- Active region: h<H_ACT && v<V_ACT, with pixel coordinate (h,v).
- HS is low for H_ACT+H_FRONT <= h < H_ACT+H_FRONT+H_SYNC. VS is low for the same window in v.
- Per object there is a shadow set {x,y,r,shape,colour} and an active set.
- An accepted command writes the shadow set only.
- Commit cycle: h==H_TOTAL-1 && v==V_ACT-1. On this cycle all shadow sets copy into the active sets, frame_start=1 and cmd_ready=0.
- cmd_ready is 1 on every other cycle outside reset.
- Hit tests use the active set with signed dx=h-x and dy=v-y (13-bit):
  - square: |dx|<=r && |dy|<=r
  - circle: dx*dx+dy*dy <= r*r, computed on 26-bit unsigned products/sum with no truncation
  - triangle (apex up): -r<=dy<=r && 2|dx| <= dy+r
  - shape 0: never hits
- Priority: the lowest-index hitting object wins. If no object hits, output BG. Outside the active region, RGB=0.
- Reset values:
  - h=v=0
  - vga_hs=vga_vs=1, vga_blank_n=0, RGB=0, frame_start=0, cmd_ready=0
  - all shadow and active fields 0, so every shape is none

## Timing
- Pipeline stage 1 registers dx/dy and the products. Stage 2 registers the priority-resolved colour onto the pins.
- vga_r/g/b, vga_hs, vga_vs and vga_blank_n all reflect counter state (h,v) exactly 2 cycles later. Syncs are delayed by matched registers.
- Command latency: a shadow write completes 1 cycle after acceptance.
- A command is visible from the first active pixel of the next frame if accepted before the commit cycle. A command accepted after the commit cycle waits one more frame.
- Two commands to the same object field in one frame: the last one wins.
- The commit cycle stalls cmd_valid for exactly one cycle. The command must be held and is accepted on the next cycle.
- Async reset mid-frame: all state returns to reset values immediately. The first cycle after release has cmd_ready=1 and h=0, v=0.
- Objects partially off-screen (x+r>=H_ACT, or x<r) are clipped naturally, with no wrap-around into opposite edges.

## Test plan
- Reset: hold rst=0 for 5 cycles -> hs=vs=1, blank_n=0, RGB=0, cmd_ready=0. After release, frame 1 is all BG with blank_n high for 640x480 pixels.
- Timing: run 2 frames -> 800 cycles per line, 525 lines; HS low for 96 cycles starting at h=656; VS low for 2 lines starting at v=490; frame_start once per 420000 cycles.
- Deferred update: write obj0 circle x=100,y=100,r=10,colour=24'h00ff00 mid-frame 1 -> frame 1 shows BG at (110,100); frame 2 shows green at (110,100) and (106,108); BG at (108,107) and (111,100).
- Priority: obj0 red square (200,200,r=20) and obj1 blue square (210,200,r=20) -> (215,200) red, (225,200) blue, (235,200) BG.
- Triangle at (320,240,r=40): (320,200) lit, (321,200) BG, (280,280) lit, (279,280) BG.
- Commit stall: assert cmd_valid on the commit cycle -> cmd_ready=0 that cycle; accepted the next cycle; value appears one frame later.

Source files
------------

// File: rtl/vga_obj_engine.sv
// VGA timing generator that renders N_OBJ shadow/active double-buffered shapes over a background.
// Stage 1 registers per-object offsets and squares; stage 2 resolves priority onto the pins.
module vga_obj_engine #(
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned V_FRONT = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned N_OBJ   = 4,
  parameter logic [23:0] BG      = 24'h000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(N_OBJ)-1:0]   cmd_obj,
  input  logic [2:0]                 cmd_field,
  input  logic [23:0]                cmd_data,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_blank_n,
  output logic [7:0]                 vga_r,
  output logic [7:0]                 vga_g,
  output logic [7:0]                 vga_b,
  output logic                       frame_start
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned CRD_W = 11;
  localparam int unsigned D_W   = 13;
  localparam int unsigned P_W   = 26;
  localparam int unsigned E_W   = 15;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACT + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACT + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] V_CMT  = CNT_W'(V_ACT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACT + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACT + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACT + V_FRONT + V_SYNC);

  localparam logic [1:0] SH_SQ = 2'd1;
  localparam logic [1:0] SH_CI = 2'd2;
  localparam logic [1:0] SH_TR = 2'd3;

  typedef struct packed {
    logic [CRD_W-1:0] x;
    logic [CRD_W-1:0] y;
    logic [CRD_W-1:0] r;
    logic [1:0]       shape;
    logic [23:0]      colour;
  } obj_t;

  logic             r_run;
  logic [CNT_W-1:0] r_h, r_v;
  logic [CNT_W-1:0] w_h_nxt, w_v_nxt;
  logic             w_commit, w_commit_nxt, w_acc;
  logic             r_cmd_ready, r_frame_start;

  obj_t r_shadow [N_OBJ];
  obj_t r_active [N_OBJ];

  // Counters hold for the first edge after reset so that cycle shows h=v=0 with ready high.
  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (r_run) begin
      if (r_h == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        w_h_nxt = r_h + 1'b1;
      end
    end
  end

  assign w_commit     = (r_h == H_LAST) && (r_v == V_CMT);
  assign w_commit_nxt = (w_h_nxt == H_LAST) && (w_v_nxt == V_CMT);
  assign w_acc        = cmd_valid && r_cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run         <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_cmd_ready   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_cmd_ready   <= !w_commit_nxt;
      r_frame_start <= w_commit_nxt;
    end
  end

  // Commands land in the shadow set; the whole shadow set is copied on the commit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_acc) begin
        case (cmd_field)
          3'd0:    r_shadow[cmd_obj].x      <= cmd_data[CRD_W-1:0];
          3'd1:    r_shadow[cmd_obj].y      <= cmd_data[CRD_W-1:0];
          3'd2:    r_shadow[cmd_obj].r      <= cmd_data[CRD_W-1:0];
          3'd3:    r_shadow[cmd_obj].shape  <= cmd_data[1:0];
          3'd4:    r_shadow[cmd_obj].colour <= cmd_data;
          default: ;
        endcase
      end
      if (w_commit) begin
        for (int i = 0; i < N_OBJ; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  logic signed [D_W-1:0] w_dx [N_OBJ];
  logic signed [D_W-1:0] w_dy [N_OBJ];
  logic [D_W-1:0]        w_adx [N_OBJ];
  logic [D_W-1:0]        w_ady [N_OBJ];
  logic                  w_act, w_hs, w_vs;

  always_comb begin
    for (int i = 0; i < N_OBJ; i++) begin
      w_dx[i]  = $signed({1'b0, r_h}) - $signed({2'b00, r_active[i].x});
      w_dy[i]  = $signed({1'b0, r_v}) - $signed({2'b00, r_active[i].y});
      w_adx[i] = w_dx[i][D_W-1] ? D_W'(-w_dx[i]) : D_W'(w_dx[i]);
      w_ady[i] = w_dy[i][D_W-1] ? D_W'(-w_dy[i]) : D_W'(w_dy[i]);
    end
  end

  assign w_act = (r_h < H_ACT_C) && (r_v < V_ACT_C);
  assign w_hs  = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign w_vs  = !((r_v >= VS_BEG) && (r_v < VS_END));

  logic [D_W-1:0]        r_s1_adx [N_OBJ];
  logic [D_W-1:0]        r_s1_ady [N_OBJ];
  logic signed [D_W-1:0] r_s1_dy  [N_OBJ];
  logic [P_W-1:0]        r_s1_dx2 [N_OBJ];
  logic [P_W-1:0]        r_s1_dy2 [N_OBJ];
  logic                  r_s1_act, r_s1_hs, r_s1_vs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        r_s1_adx[i] <= '0;
        r_s1_ady[i] <= '0;
        r_s1_dy[i]  <= '0;
        r_s1_dx2[i] <= '0;
        r_s1_dy2[i] <= '0;
      end
      r_s1_act <= 1'b0;
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
    end else begin
      for (int i = 0; i < N_OBJ; i++) begin
        r_s1_adx[i] <= w_adx[i];
        r_s1_ady[i] <= w_ady[i];
        r_s1_dy[i]  <= w_dy[i];
        r_s1_dx2[i] <= P_W'(w_adx[i]) * P_W'(w_adx[i]);
        r_s1_dy2[i] <= P_W'(w_ady[i]) * P_W'(w_ady[i]);
      end
      r_s1_act <= w_act;
      r_s1_hs  <= w_hs;
      r_s1_vs  <= w_vs;
    end
  end

  logic [P_W-1:0]        w_rr  [N_OBJ];
  logic signed [E_W-1:0] w_rs  [N_OBJ];
  logic signed [E_W-1:0] w_dys [N_OBJ];
  logic signed [E_W-1:0] w_lhs [N_OBJ];
  logic [N_OBJ-1:0]      w_hit;
  logic [23:0]           w_pix;

  // Shape hit tests; the triangle test is 2|dx| <= dy+r in widened signed arithmetic.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      w_rr[i]  = P_W'(r_active[i].r) * P_W'(r_active[i].r);
      w_rs[i]  = $signed({4'b0000, r_active[i].r});
      w_dys[i] = $signed({{2{r_s1_dy[i][D_W-1]}}, r_s1_dy[i]});
      w_lhs[i] = $signed({1'b0, r_s1_adx[i], 1'b0});
      case (r_active[i].shape)
        SH_SQ:   w_hit[i] = (r_s1_adx[i] <= {2'b00, r_active[i].r}) &&
                            (r_s1_ady[i] <= {2'b00, r_active[i].r});
        SH_CI:   w_hit[i] = (r_s1_dx2[i] + r_s1_dy2[i]) <= w_rr[i];
        SH_TR:   w_hit[i] = (w_dys[i] >= -w_rs[i]) && (w_dys[i] <= w_rs[i]) &&
                            (w_lhs[i] <= w_dys[i] + w_rs[i]);
        default: w_hit[i] = 1'b0;
      endcase
    end
  end

  // Lowest-index hit wins, so scan from the top down.
  always_comb begin
    w_pix = BG;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (w_hit[i]) w_pix = r_active[i].colour;
    end
  end

  logic [23:0] r_rgb;
  logic        r_hs, r_vs, r_blank_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb     <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_rgb     <= r_s1_act ? w_pix : 24'h000000;
      r_hs      <= r_s1_hs;
      r_vs      <= r_s1_vs;
      r_blank_n <= r_s1_act;
    end
  end

  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign cmd_ready   = r_cmd_ready;
  assign frame_start = r_frame_start;

endmodule
